cpu_multicycle: RTL and testbench

Parametrised multi-cycle successor to the current single-path CPU core. It executes the existing 32-bit instruction format (opcode[31:28], Rd[27:24], Ra[23:20], Rb[19:16], imm[15:0]) through an explicit fetch/decode/execute/memory/writeback state machine. It uses a single shared memory port with a req/ready handshake, so wait-state memories and the integrated memory block attach directly. It sits between the board top level and the memory subsystem, replacing the divided-clock scheme with one clock.

---
 rtl/cpu_multicycle.sv | 239 +++++++++++++++++++++++
 tb/tb_cpu_multicycle.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_multicycle.sv
// cpu_multicycle: multi-cycle 32-bit-instruction core with one shared
// req/ready memory port. Instructions step through FETCH, DECODE, EXEC,
// MEM (loads/stores only) and WB (register writers only).
// Optional build macro CPU_MUL_EN: opcode 7 becomes an unsigned MUL
// (low DATA_W bits). When undefined, opcode 7 is a signed SLT and
// no multiplier is built.
module cpu_multicycle #(
    parameter int                DATA_W   = 32,
    parameter int                NREGS    = 16,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] pc,
    output logic [31:0]       instr,
    output logic              retire,
    output logic              halted
);
    localparam int SH_W = $clog2(DATA_W);
    localparam logic [DATA_W-1:0] PC_STEP = DATA_W'(32'd4);
    localparam logic [DATA_W-1:0] ONE     = DATA_W'(32'd1);

    localparam logic [3:0] OP_ADD     = 4'h0;
    localparam logic [3:0] OP_SUB     = 4'h1;
    localparam logic [3:0] OP_AND     = 4'h2;
    localparam logic [3:0] OP_OR      = 4'h3;
    localparam logic [3:0] OP_XOR     = 4'h4;
    localparam logic [3:0] OP_SLL     = 4'h5;
    localparam logic [3:0] OP_SRL     = 4'h6;
    localparam logic [3:0] OP_SLT_MUL = 4'h7;
    localparam logic [3:0] OP_ADDI    = 4'h8;
    localparam logic [3:0] OP_ORI     = 4'h9;
    localparam logic [3:0] OP_LW      = 4'hA;
    localparam logic [3:0] OP_SW      = 4'hB;
    localparam logic [3:0] OP_BEQ     = 4'hC;
    localparam logic [3:0] OP_JAL     = 4'hD;
    localparam logic [3:0] OP_JR      = 4'hE;
    localparam logic [3:0] OP_HALT    = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t            state_r;
    logic [DATA_W-1:0] rf_r [NREGS];
    logic [DATA_W-1:0] pc_r, a_r, b_r, imm_r, result_r, next_pc_r;
    logic [DATA_W-1:0] mem_addr_r, mem_wdata_r;
    logic [31:0]       instr_r;
    logic              mem_req_r, mem_we_r, halted_r;

    logic [3:0]        op_s, rd_s, ra_s, rb_s;
    logic [DATA_W-1:0] alu_s, npc_s, pc_plus4_s, ea_s, br_tgt_s;
    logic              retire_s;

    assign op_s = instr_r[31:28];
    assign rd_s = instr_r[27:24];
    assign ra_s = instr_r[23:20];
    assign rb_s = instr_r[19:16];

    // ALU result, effective address and next-PC selection for the EXEC stage
    always_comb begin
        pc_plus4_s = pc_r + PC_STEP;
        br_tgt_s   = pc_r + imm_r;
        ea_s       = a_r + imm_r;
        alu_s      = '0;
        npc_s      = pc_plus4_s;
        case (op_s)
            OP_ADD:  alu_s = a_r + b_r;
            OP_SUB:  alu_s = a_r - b_r;
            OP_AND:  alu_s = a_r & b_r;
            OP_OR:   alu_s = a_r | b_r;
            OP_XOR:  alu_s = a_r ^ b_r;
            OP_SLL:  alu_s = a_r << b_r[SH_W-1:0];
            OP_SRL:  alu_s = a_r >> b_r[SH_W-1:0];
            OP_SLT_MUL: begin
`ifdef CPU_MUL_EN
                alu_s = a_r * b_r;
`else
                alu_s = ($signed(a_r) < $signed(b_r)) ? ONE : '0;
`endif
            end
            OP_ADDI: alu_s = ea_s;
            OP_ORI:  alu_s = a_r | DATA_W'(instr_r[15:0]);
            OP_LW:   alu_s = ea_s;
            OP_SW:   alu_s = ea_s;
            OP_BEQ:  npc_s = (a_r == b_r) ? br_tgt_s : pc_plus4_s;
            OP_JAL: begin
                alu_s = pc_plus4_s;
                npc_s = br_tgt_s;
            end
            OP_JR:   npc_s = a_r;
            default: alu_s = '0;
        endcase
    end

    // Retire marks the last cycle of an instruction; a store ends on its handshake
    always_comb begin
        retire_s = 1'b0;
        if (state_r == S_WB) begin
            retire_s = 1'b1;
        end else if (state_r == S_EXEC && (op_s == OP_BEQ || op_s == OP_JR)) begin
            retire_s = 1'b1;
        end else if (state_r == S_MEM && op_s == OP_SW && mem_req_r && mem_ready) begin
            retire_s = 1'b1;
        end else begin
            retire_s = 1'b0;
        end
    end

    // Control FSM, datapath latches, register file and memory port registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= S_FETCH;
            pc_r        <= RESET_PC;
            instr_r     <= 32'h0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            halted_r    <= 1'b0;
            a_r         <= '0;
            b_r         <= '0;
            imm_r       <= '0;
            result_r    <= '0;
            next_pc_r   <= '0;
            for (int i = 0; i < NREGS; i++) begin
                rf_r[i] <= '0;
            end
        end else begin
            case (state_r)
                S_FETCH: begin
                    if (!mem_req_r) begin
                        // only reached straight out of reset
                        mem_req_r  <= 1'b1;
                        mem_we_r   <= 1'b0;
                        mem_addr_r <= pc_r;
                    end else if (mem_ready) begin
                        mem_req_r <= 1'b0;
                        instr_r   <= 32'(mem_rdata);
                        state_r   <= S_DECODE;
                    end else begin
                        state_r <= S_FETCH;
                    end
                end
                S_DECODE: begin
                    a_r     <= rf_r[ra_s];
                    b_r     <= rf_r[rb_s];
                    imm_r   <= DATA_W'($signed(instr_r[15:0]));
                    state_r <= S_EXEC;
                end
                S_EXEC: begin
                    result_r  <= alu_s;
                    next_pc_r <= npc_s;
                    case (op_s)
                        OP_LW, OP_SW: begin
                            mem_req_r  <= 1'b1;
                            mem_we_r   <= (op_s == OP_SW);
                            mem_addr_r <= ea_s;
                            if (op_s == OP_SW) begin
                                mem_wdata_r <= b_r;
                            end else begin
                                mem_wdata_r <= mem_wdata_r;
                            end
                            state_r <= S_MEM;
                        end
                        OP_HALT: begin
                            halted_r <= 1'b1;
                            state_r  <= S_HALT;
                        end
                        OP_BEQ, OP_JR: begin
                            pc_r       <= npc_s;
                            mem_req_r  <= 1'b1;
                            mem_we_r   <= 1'b0;
                            mem_addr_r <= npc_s;
                            state_r    <= S_FETCH;
                        end
                        default: state_r <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (op_s == OP_SW) begin
                            pc_r       <= pc_plus4_s;
                            mem_req_r  <= 1'b1;
                            mem_we_r   <= 1'b0;
                            mem_addr_r <= pc_plus4_s;
                            state_r    <= S_FETCH;
                        end else begin
                            mem_req_r <= 1'b0;
                            mem_we_r  <= 1'b0;
                            result_r  <= mem_rdata;
                            state_r   <= S_WB;
                        end
                    end else begin
                        state_r <= S_MEM;
                    end
                end
                S_WB: begin
                    if (rd_s != 4'd0) begin
                        rf_r[rd_s] <= result_r;
                    end else begin
                        rf_r[0] <= '0;
                    end
                    pc_r       <= next_pc_r;
                    mem_req_r  <= 1'b1;
                    mem_we_r   <= 1'b0;
                    mem_addr_r <= next_pc_r;
                    state_r    <= S_FETCH;
                end
                S_HALT: begin
                    mem_req_r <= 1'b0;
                    halted_r  <= 1'b1;
                    state_r   <= S_HALT;
                end
                default: state_r <= S_FETCH;
            endcase
        end
    end

    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign pc        = pc_r;
    assign instr     = instr_r;
    assign retire    = retire_s;
    assign halted    = halted_r;
endmodule

// File: tb/tb_cpu_multicycle.sv
// Self-checking bench for cpu_multicycle: a table of ALU programs plus
// directed sequences for wait states, branches, jumps, R0, HALT and reset.
module tb_cpu_multicycle;
    logic        clk = 1'b0;
    logic        rst, mem_req, mem_we, mem_ready, retire, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc, instr;
    logic [31:0] mem [0:1023];
    int          total = 0;
    int          bad   = 0;
    logic        req_h  [0:511];
    logic [31:0] addr_h [0:511];
    int          ret_log[$];
    logic [31:0] rd_log[$];
    logic [31:0] exp_rd [7];
    int          req_cnt;

    typedef struct {
        string       nm;
        logic [3:0]  op;
        logic [15:0] ia;
        logic [15:0] ib;
        logic [31:0] exp;
    } vec_t;
    vec_t vt [14];

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[11:2]];

    cpu_multicycle #(.DATA_W(32), .NREGS(16), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .pc(pc), .instr(instr), .retire(retire),
        .halted(halted)
    );

    function automatic logic [31:0] ins(input logic [3:0] op, input logic [3:0] rd,
                                        input logic [3:0] ra, input logic [3:0] rb,
                                        input logic [15:0] imm);
        return {op, rd, ra, rb, imm};
    endfunction

    function automatic logic [31:0] ret_at(input int k);
        if (k < ret_log.size()) return 32'(ret_log[k]);
        return 32'hFFFFFFFF;
    endfunction

    function automatic logic [31:0] rd_at(input int k);
        if (k < rd_log.size()) return rd_log[k];
        return 32'hFFFFFFFF;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    endtask

    // reset, release, then run until halted; mem_ready low in cycles st_lo..st_hi
    task automatic run_prog(input int budget, input int st_lo, input int st_hi);
        int c;
        ret_log.delete();
        rd_log.delete();
        rst = 1'b0;
        mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        c = 0;
        while (c < budget && !halted) begin
            @(posedge clk);
            #1;
            c++;
            mem_ready = (c >= st_lo && c <= st_hi) ? 1'b0 : 1'b1;
            #1;
            if (c < 512) begin
                req_h[c]  = mem_req;
                addr_h[c] = mem_addr;
            end
            if (retire) ret_log.push_back(c);
            if (mem_req && mem_ready) begin
                if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
                else rd_log.push_back(mem_addr);
            end
        end
        chk("halt_reached", {31'd0, halted}, 32'd1);
    endtask

    initial begin
        rst = 1'b0;
        mem_ready = 1'b1;

        vt[0]  = '{"add",      4'h0, 16'h0005, 16'h0007, 32'h0000000C};
        vt[1]  = '{"sub",      4'h1, 16'h0005, 16'h0007, 32'hFFFFFFFE};
        vt[2]  = '{"add_wrap", 4'h0, 16'hFFFF, 16'h0001, 32'h00000000};
        vt[3]  = '{"and",      4'h2, 16'h0F0F, 16'h00FF, 32'h0000000F};
        vt[4]  = '{"or",       4'h3, 16'h0F0F, 16'h00FF, 32'h00000FFF};
        vt[5]  = '{"xor",      4'h4, 16'h0F0F, 16'h00FF, 32'h00000FF0};
        vt[6]  = '{"sll_31",   4'h5, 16'h0001, 16'd31,   32'h80000000};
        vt[7]  = '{"sll_33",   4'h5, 16'h0001, 16'd33,   32'h00000002};
        vt[8]  = '{"srl",      4'h6, 16'hFFF0, 16'h0004, 32'h0FFFFFFF};
`ifdef CPU_MUL_EN
        vt[9]  = '{"mul_a",    4'h7, 16'hFFFF, 16'h0001, 32'hFFFFFFFF};
        vt[10] = '{"mul_b",    4'h7, 16'h0001, 16'hFFFF, 32'hFFFFFFFF};
        vt[11] = '{"mul_6x7",  4'h7, 16'h0006, 16'h0007, 32'd42};
`else
        vt[9]  = '{"slt_neg",  4'h7, 16'hFFFF, 16'h0001, 32'h00000001};
        vt[10] = '{"slt_pos",  4'h7, 16'h0001, 16'hFFFF, 32'h00000000};
        vt[11] = '{"slt_6_7",  4'h7, 16'h0006, 16'h0007, 32'h00000001};
`endif
        vt[12] = '{"addi_neg", 4'h8, 16'h0010, 16'hFFFF, 32'h0000000F};
        vt[13] = '{"ori_zext", 4'h9, 16'h0100, 16'h8001, 32'h00008101};

        // table: load R1/R2, apply op into R3, store R3 at 0x300, halt
        foreach (vt[i]) begin
            clear_mem();
            mem[0]   = ins(4'h8, 4'd1, 4'd0, 4'd0, vt[i].ia);
            mem[1]   = ins(4'h8, 4'd2, 4'd0, 4'd0, vt[i].ib);
            mem[2]   = ins(vt[i].op, 4'd3, 4'd1, 4'd2, vt[i].ib);
            mem[3]   = ins(4'hB, 4'd0, 4'd0, 4'd3, 16'h0300);
            mem[4]   = ins(4'hF, 4'd0, 4'd0, 4'd0, 16'h0000);
            mem[192] = 32'hDEADBEEF;
            run_prog(100, 0, 0);
            chk(vt[i].nm, mem[192], vt[i].exp);
        end

        // reset values, taken after a halted run left state non-zero
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_retire", {31'd0, retire}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);

        // basic program, zero-wait
        clear_mem();
        mem[0]  = ins(4'h8, 4'd1, 4'd0, 4'd0, 16'd5);
        mem[1]  = ins(4'h8, 4'd2, 4'd0, 4'd0, 16'd7);
        mem[2]  = ins(4'h0, 4'd3, 4'd1, 4'd2, 16'd0);
        mem[3]  = ins(4'hB, 4'd0, 4'd0, 4'd3, 16'h0100);
        mem[4]  = ins(4'hF, 4'd0, 4'd0, 4'd0, 16'h0000);
        mem[64] = 32'hDEADBEEF;
        run_prog(100, 0, 0);
        chk("first_req", {31'd0, req_h[1]}, 32'd1);
        chk("first_addr", addr_h[1], 32'h0);
        chk("sum_store", mem[64], 32'd12);
        chk("ret_count", 32'(ret_log.size()), 32'd4);
        chk("ret0", ret_at(0), 32'd4);
        chk("ret1", ret_at(1), 32'd8);
        chk("ret2", ret_at(2), 32'd12);
        chk("ret3", ret_at(3), 32'd16);

        // same program, fetch at pc=0 stalled three cycles
        mem[64] = 32'hDEADBEEF;
        run_prog(100, 1, 3);
        for (int c = 1; c <= 3; c++) begin
            chk("stall_req", {31'd0, req_h[c]}, 32'd1);
            chk("stall_addr", addr_h[c], 32'h0);
        end
        chk("stall_ret0", ret_at(0), 32'd7);
        chk("stall_store", mem[64], 32'd12);

        // BEQ taken at 0x10, then not taken at 0x18
        clear_mem();
        mem[0] = ins(4'h8, 4'd1, 4'd0, 4'd0, 16'd3);
        mem[1] = ins(4'h8, 4'd2, 4'd0, 4'd0, 16'd4);
        mem[4] = ins(4'hC, 4'd0, 4'd1, 4'd1, 16'h0008);
        mem[6] = ins(4'hC, 4'd0, 4'd1, 4'd2, 16'h0008);
        mem[7] = ins(4'hF, 4'd0, 4'd0, 4'd0, 16'h0000);
        run_prog(100, 0, 0);
        exp_rd = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h18, 32'h1C};
        for (int k = 0; k < 7; k++) chk("beq_fetch", rd_at(k), exp_rd[k]);
        chk("beq_taken_ret", ret_at(4), 32'd19);
        chk("beq_fall_ret", ret_at(5), 32'd22);

        // BEQ not taken at 0x10 falls through to 0x14
        mem[4] = ins(4'hC, 4'd0, 4'd1, 4'd2, 16'h0008);
        mem[5] = ins(4'hF, 4'd0, 4'd0, 4'd0, 16'h0000);
        run_prog(100, 0, 0);
        chk("beq_nt_fetch", rd_at(5), 32'h14);

        // JAL R5,+0x20 at 0x40, JR R5 at 0x60, store R5
        clear_mem();
        mem[0]   = ins(4'hD, 4'd0, 4'd0, 4'd0, 16'h0040);
        mem[16]  = ins(4'hD, 4'd5, 4'd0, 4'd0, 16'h0020);
        mem[24]  = ins(4'hE, 4'd0, 4'd5, 4'd0, 16'h0000);
        mem[17]  = ins(4'hB, 4'd0, 4'd0, 4'd5, 16'h0204);
        mem[18]  = ins(4'hF, 4'd0, 4'd0, 4'd0, 16'h0000);
        mem[129] = 32'hDEADBEEF;
        run_prog(100, 0, 0);
        chk("jal_fetch", rd_at(2), 32'h60);
        chk("jr_fetch", rd_at(3), 32'h44);
        chk("jal_link", mem[129], 32'h44);
        chk("jr_ret", ret_at(2), 32'd11);
        chk("sw_ret", ret_at(3), 32'd15);

        // R0 stays zero, then HALT keeps the port idle
        clear_mem();
        mem[0]   = ins(4'h8, 4'd0, 4'd0, 4'd0, 16'd9);
        mem[1]   = ins(4'hB, 4'd0, 4'd0, 4'd0, 16'h0200);
        mem[2]   = ins(4'hF, 4'd0, 4'd0, 4'd0, 16'h0000);
        mem[128] = 32'hDEADBEEF;
        run_prog(100, 0, 0);
        chk("r0_store", mem[128], 32'h0);
        req_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (mem_req) req_cnt++;
        end
        chk("halt_idle_req", 32'(req_cnt), 32'd0);
        chk("halt_stays", {31'd0, halted}, 32'd1);

        // reset while a load waits in MEM
        clear_mem();
        mem[0]   = ins(4'h8, 4'd4, 4'd0, 4'd0, 16'h0055);
        mem[1]   = ins(4'hA, 4'd4, 4'd0, 4'd0, 16'h0300);
        mem[2]   = ins(4'hF, 4'd0, 4'd0, 4'd0, 16'h0000);
        mem[192] = 32'h00000099;
        rst = 1'b0;
        mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            if (c == 8) mem_ready = 1'b0;
        end
        #1;
        chk("lw_req", {31'd0, mem_req}, 32'd1);
        chk("lw_addr", mem_addr, 32'h300);
        chk("lw_we", {31'd0, mem_we}, 32'd0);
        @(posedge clk);
        #1;
        chk("lw_wait_req", {31'd0, mem_req}, 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_req", {31'd0, mem_req}, 32'd0);
        chk("abort_pc", pc, 32'h0);
        mem_ready = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("restart_req", {31'd0, mem_req}, 32'd1);
        chk("restart_addr", mem_addr, 32'h0);
        // the aborted load must not have landed in R4
        clear_mem();
        mem[0]   = ins(4'hB, 4'd0, 4'd0, 4'd4, 16'h0304);
        mem[1]   = ins(4'hF, 4'd0, 4'd0, 4'd0, 16'h0000);
        mem[193] = 32'hFFFFFFFF;
        run_prog(100, 0, 0);
        chk("rd_unchanged", mem[193], 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
